lsu_sequencer: RTL and testbench
================================

// Module: lsu_sequencer
// PURPOSE
//  Sequences every core load/store onto the single data-memory port.
//  - Accepts one request at a time, computes byte enables and lane-shifted store data.
//  - Splits word/half accesses that cross a 32-bit boundary into two aligned beats.
//  - Assembles and sign/zero-extends load data, then returns one response per request.
//  - Sits between the core's execute/memory stage and the data memory/cache.
// PARAMETERS
//  SPLIT_EN  1  1: split boundary-crossing accesses into two beats; 0: reject them with rsp_err
// PORTS
//  clk              in   1   single clock, all state changes on rising edge
//  rst_n            in   1   synchronous, active-low reset
//  req_valid        in   1   core request valid
//  req_ready        out  1   sequencer can accept (high only in IDLE)
//  req_we           in   1   1 = store, 0 = load
//  req_f3           in   3   funct3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW
//  req_addr         in   32  byte address
//  req_wdata        in   32  store source register value
//  rsp_valid        out  1   one-cycle pulse: request complete
//  rsp_rdata        out  32  extended load result (0 for stores and errors)
//  rsp_err          out  1   qualifies rsp_valid: illegal f3, or crossing access with SPLIT_EN=0
//  mem_valid        out  1   memory beat valid
//  mem_ready        in   1   memory accepts beat; for reads, mem_rdata valid in same cycle
//  mem_we           out  1   beat is a write
//  mem_addr         out  32  word-aligned beat address ([1:0]=00)
//  mem_byte_enable  out  4   byte lanes of this beat
//  mem_wdata        out  32  lane-aligned write data
//  mem_rdata        in   32  read data
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; mem_valid, rsp_valid and rsp_err = 0.
//   rsp_rdata, mem_addr, mem_byte_enable and mem_wdata = 0. req_ready=1 the cycle after reset.
//  FSM: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid, latch we/f3/addr/wdata.
//   - off=addr[1:0]; size=1/2/4 bytes from f3[1:0].
//   - cross = off+size>4.
//   - illegal f3 (load 011/110/111; store f3[2]=1 or 011) or (cross & !SPLIT_EN): go to RESP with err=1; no mem beat.
//  Lanes: 64-bit mask = ((1<<size)-1)<<off; 64-bit data = wdata<<(8*off).
//   Beat0 uses bits [3:0]/[31:0], beat1 uses [7:4]/[63:32].
//  BEAT0: mem_valid=1, mem_addr={addr[31:2],2'b00}, lower mask/data.
//   All mem_* held stable until mem_ready. On ready: capture mem_rdata into buf[31:0];
//   go to BEAT1 if cross, else RESP.
//  BEAT1: mem_addr = beat0 addr + 4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000), upper mask/data.
//   Same handshake; capture into buf[63:32].
//  RESP: rsp_valid=1 for exactly one cycle.
//   - load: rsp_rdata = extend((buf>>(8*off))[size*8-1:0]); sign-extend for f3[2]=0, zero-extend otherwise.
//   - then IDLE; a new request may be accepted the following cycle.
//  Latency with mem_ready tied high: accept at T, beat0 at T+1, rsp_valid at T+2.
//   Crossing access: rsp_valid at T+3. Error: rsp_valid at T+1.
//  mem_valid never drops without mem_ready except on reset.
//  Reset mid-beat: mem_valid low after the reset edge, transaction abandoned, no rsp_valid.
//  req_valid while !req_ready is ignored (core holds it); no request queueing.
//  mem_we is constant across both beats of one request.
// STRUCTURE
//  Shared package lsu_pkg: funct3 constants (LB..LHU, SB/SH/SW), state enum lsu_state_e
//   {IDLE,BEAT0,BEAT1,RESP}, size_from_f3() function.
//  One sub-module: lsu_load_formatter (comb: 64-bit buf, off, f3 -> 32-bit extended result).
//  Lane mask/data generation stays inline in the sequencer.
// TESTING
//  1 SW 0xDEADBEEF @0x100, ready=1
//    -> one beat addr 0x100 be 1111 wdata 0xDEADBEEF; rsp_valid at T+2, err=0.
//  2 SB 0x000000A5 @0x203
//    -> addr 0x200 be 1000 wdata 0xA5000000.
//    LB @0x203 with mem_rdata 0xA5000000 -> rsp_rdata 0xFFFFFFA5. LBU -> 0x000000A5.
//  3 SW 0x11223344 @0x102, SPLIT_EN=1
//    -> beat0 addr 0x100 be 1100 wdata 0x33440000; beat1 addr 0x104 be 0011 wdata 0x00001122.
//    LH @0x103 with rdata 0x80000000/0x000000FF -> rsp_rdata 0xFFFFFF80.
//  4 mem_ready low 3 cycles during beat0 -> mem_* stable all 4 cycles; single rsp_valid after ready.
//    Reset asserted mid-stall -> mem_valid 0 next cycle, no rsp_valid, req_ready=1 after release.
//  5 Load f3=011 -> no mem_valid, rsp_valid+rsp_err at T+1, rsp_rdata 0.
//    SPLIT_EN=0 SW @0x101 -> same error response.
//  6 SH @0xFFFFFFFF -> beat0 addr 0xFFFFFFFC be 1000, beat1 addr 0x00000000 be 0001.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and access-size decoding.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_e;

  // Access size in bytes (1, 2 or 4); f3[1:0]=11 is illegal and reported separately.
  function automatic logic [2:0] size_from_f3(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and memory-side beat bundle.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (output req_valid, req_we, req_f3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_f3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_we, mem_addr, mem_byte_enable, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_we, mem_addr, mem_byte_enable, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_load_formatter.sv
// Extracts the addressed byte/half/word from the two-beat read buffer and
// sign- or zero-extends it to 32 bits.
module lsu_load_formatter
  import lsu_pkg::*;
(
  input  logic [63:0] buf_data,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(buf_data >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   rdata = f3[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   rdata = f3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Sequences one core load/store at a time onto the data-memory port, splitting
// accesses that straddle a word boundary into two aligned beats.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_e  state_q, state_d;
  logic        we_q, err_q, cross_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [63:0] rbuf_q;

  logic [2:0]  req_size, size_q;
  logic [3:0]  req_end;
  logic        req_cross, req_err, accept;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [31:0] base_addr, fmt_rdata;

  assign req_size  = size_from_f3(req.req_f3);
  assign req_end   = {2'b00, req.req_addr[1:0]} + {1'b0, req_size};
  assign req_cross = req_end > 4'd4;
  assign req_err   = f3_illegal(req.req_we, req.req_f3) || (req_cross && !SPLIT_EN);
  assign accept    = (state_q == IDLE) && req.req_valid;

  // 64-bit lane view: beat0 takes the low word, beat1 the high word.
  assign size_q    = size_from_f3(f3_q);
  assign mask8     = ((8'd1 << size_q) - 8'd1) << addr_q[1:0];
  assign data64    = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
  assign base_addr = {addr_q[31:2], 2'b00};

  lsu_load_formatter u_fmt (
    .buf_data (rbuf_q),
    .off      (addr_q[1:0]),
    .f3       (f3_q),
    .rdata    (fmt_rdata)
  );

  always_comb begin
    state_d             = state_q;
    req.req_ready       = 1'b0;
    req.rsp_valid       = 1'b0;
    req.rsp_err         = 1'b0;
    req.rsp_rdata       = 32'd0;
    mem.mem_valid       = 1'b0;
    mem.mem_we          = 1'b0;
    mem.mem_addr        = 32'd0;
    mem.mem_byte_enable = 4'd0;
    mem.mem_wdata       = 32'd0;
    case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) state_d = req_err ? RESP : BEAT0;
      end
      BEAT0: begin
        mem.mem_valid       = 1'b1;
        mem.mem_we          = we_q;
        mem.mem_addr        = base_addr;
        mem.mem_byte_enable = mask8[3:0];
        mem.mem_wdata       = data64[31:0];
        if (mem.mem_ready) state_d = cross_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem.mem_valid       = 1'b1;
        mem.mem_we          = we_q;
        mem.mem_addr        = base_addr + 32'd4;
        mem.mem_byte_enable = mask8[7:4];
        mem.mem_wdata       = data64[63:32];
        if (mem.mem_ready) state_d = RESP;
      end
      RESP: begin
        req.rsp_valid = 1'b1;
        req.rsp_err   = err_q;
        req.rsp_rdata = (err_q || we_q) ? 32'd0 : fmt_rdata;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Data registers need no reset: every output they feed is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req.req_we;
      f3_q    <= req.req_f3;
      addr_q  <= req.req_addr;
      wdata_q <= req.req_wdata;
      err_q   <= req_err;
      cross_q <= req_cross;
    end
    if (state_q == BEAT0 && mem.mem_ready) rbuf_q[31:0]  <= mem.mem_rdata;
    if (state_q == BEAT1 && mem.mem_ready) rbuf_q[63:32] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed scoreboard bench: the driver queues expected beats/responses, a
// negedge monitor pops and compares them as the sequencers present them.
module tb_lsu_sequencer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ready_tb = 1'b1;
  logic [31:0] rd_lo = 32'd0;
  logic [31:0] rd_hi = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cyc0 = 0;

  beat_t exp_beat[$];
  rsp_t  exp_rsp[$];
  rsp_t  exp_rsp0[$];
  beat_t b;
  rsp_t  r;

  lsu_req_if rq ();
  lsu_mem_if mm ();
  lsu_req_if rq0 ();
  lsu_mem_if mm0 ();

  assign mm.mem_ready  = mem_ready_tb;
  assign mm.mem_rdata  = mm.mem_addr[2] ? rd_hi : rd_lo;
  assign mm0.mem_ready = 1'b1;
  assign mm0.mem_rdata = 32'd0;

  lsu_sequencer #(.SPLIT_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .req(rq.slave),  .mem(mm.master));
  lsu_sequencer #(.SPLIT_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .req(rq0.slave), .mem(mm0.master));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rq.req_valid && rq.req_ready)   acc_cyc  = cyc;
      if (rq0.req_valid && rq0.req_ready) acc_cyc0 = cyc;
      if (mm.mem_valid) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_beat", mm.mem_addr, 32'hxxxx_xxxx);
        end else begin
          b = exp_beat[0];
          chk("beat_we",   {31'd0, mm.mem_we}, {31'd0, b.we});
          chk("beat_addr", mm.mem_addr, b.addr);
          chk("beat_be",   {28'd0, mm.mem_byte_enable}, {28'd0, b.be});
          chk("beat_wdata", mm.mem_wdata, b.wdata);
          if (mm.mem_ready) void'(exp_beat.pop_front());
        end
      end
      if (rq.rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rq.rsp_valid}, 32'd0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata",   rq.rsp_rdata, r.rdata);
          chk("rsp_err",     {31'd0, rq.rsp_err}, {31'd0, r.err});
          chk("rsp_latency", cyc - acc_cyc, r.lat);
        end
      end
      if (rq0.rsp_valid) begin
        if (exp_rsp0.size() == 0) begin
          chk("unexpected_rsp0", {31'd0, rq0.rsp_valid}, 32'd0);
        end else begin
          r = exp_rsp0.pop_front();
          chk("rsp0_rdata",   rq0.rsp_rdata, r.rdata);
          chk("rsp0_err",     {31'd0, rq0.rsp_err}, {31'd0, r.err});
          chk("rsp0_latency", cyc - acc_cyc0, r.lat);
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_rsp0.size() != 0 || exp_beat.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      chk("timeout", exp_rsp.size() + exp_rsp0.size() + exp_beat.size(), 32'd0);
      exp_rsp.delete();
      exp_rsp0.delete();
      exp_beat.delete();
    end
    @(posedge clk); #1;
  endtask

  // Presents one request to dut (which=0) or dut0 (which=1); both are idle here.
  task automatic send(input bit which, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    if (!which) begin
      rq.req_we = we; rq.req_f3 = f3; rq.req_addr = addr; rq.req_wdata = wdata;
      rq.req_valid = 1'b1;
    end else begin
      rq0.req_we = we; rq0.req_f3 = f3; rq0.req_addr = addr; rq0.req_wdata = wdata;
      rq0.req_valid = 1'b1;
    end
    @(posedge clk); #1;
    rq.req_valid  = 1'b0;
    rq0.req_valid = 1'b0;
  endtask

  task automatic eb(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    exp_beat.push_back('{we: we, addr: addr, be: be, wdata: wd});
  endtask

  task automatic er(input logic [31:0] rd, input logic err, input int lat);
    exp_rsp.push_back('{rdata: rd, err: err, lat: lat});
  endtask

  initial begin
    rq.req_valid = 1'b0;  rq.req_we = 1'b0;  rq.req_f3 = 3'd0;  rq.req_addr = 32'd0;  rq.req_wdata = 32'd0;
    rq0.req_valid = 1'b0; rq0.req_we = 1'b0; rq0.req_f3 = 3'd0; rq0.req_addr = 32'd0; rq0.req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", {31'd0, rq.req_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mm.mem_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rq.rsp_valid}, 32'd0);
    chk("rst_mem_addr",  mm.mem_addr, 32'd0);
    chk("rst_mem_be",    {28'd0, mm.mem_byte_enable}, 32'd0);
    chk("rst_rsp_rdata", rq.rsp_rdata, 32'd0);

    // Aligned word store
    eb(1, 32'h100, 4'b1111, 32'hDEADBEEF); er(32'd0, 0, 2);
    send(0, 1, 3'b010, 32'h100, 32'hDEADBEEF); wait_done();

    // Byte store and byte/half/word loads
    eb(1, 32'h200, 4'b1000, 32'hA5000000); er(32'd0, 0, 2);
    send(0, 1, 3'b000, 32'h203, 32'h000000A5); wait_done();
    rd_lo = 32'hA5000000;
    eb(0, 32'h200, 4'b1000, 32'd0); er(32'hFFFFFFA5, 0, 2);
    send(0, 0, 3'b000, 32'h203, 32'd0); wait_done();
    eb(0, 32'h200, 4'b1000, 32'd0); er(32'h000000A5, 0, 2);
    send(0, 0, 3'b100, 32'h203, 32'd0); wait_done();
    eb(0, 32'h200, 4'b1100, 32'd0); er(32'h0000A500, 0, 2);
    send(0, 0, 3'b101, 32'h202, 32'd0); wait_done();

    // Crossing store and crossing load
    eb(1, 32'h100, 4'b1100, 32'h33440000); eb(1, 32'h104, 4'b0011, 32'h00001122); er(32'd0, 0, 3);
    send(0, 1, 3'b010, 32'h102, 32'h11223344); wait_done();
    rd_lo = 32'h80000000; rd_hi = 32'h000000FF;
    eb(0, 32'h100, 4'b1000, 32'd0); eb(0, 32'h104, 4'b0001, 32'd0); er(32'hFFFFFF80, 0, 3);
    send(0, 0, 3'b001, 32'h103, 32'd0); wait_done();

    // Three-cycle stall in beat0
    eb(1, 32'h300, 4'b1111, 32'hCAFEF00D); er(32'd0, 0, 5);
    @(posedge clk); #1;
    rq.req_we = 1'b1; rq.req_f3 = 3'b010; rq.req_addr = 32'h300; rq.req_wdata = 32'hCAFEF00D;
    rq.req_valid = 1'b1;
    @(posedge clk); #1;
    rq.req_valid = 1'b0; mem_ready_tb = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready_tb = 1'b1;
    wait_done();

    // Reset while a beat is stalled abandons the transaction
    eb(1, 32'h400, 4'b1111, 32'h5A5A5A5A);
    rq.req_we = 1'b1; rq.req_f3 = 3'b010; rq.req_addr = 32'h400; rq.req_wdata = 32'h5A5A5A5A;
    rq.req_valid = 1'b1;
    @(posedge clk); #1;
    rq.req_valid = 1'b0; mem_ready_tb = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_beat.delete();
    chk("midrst_mem_valid", {31'd0, mm.mem_valid}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rq.rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, rq.req_ready}, 32'd1);
    mem_ready_tb = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Illegal funct3 and unsplit crossing access
    er(32'd0, 1, 1);
    send(0, 0, 3'b011, 32'h100, 32'd0); wait_done();
    er(32'd0, 1, 1);
    send(0, 1, 3'b100, 32'h100, 32'h12345678); wait_done();
    exp_rsp0.push_back('{rdata: 32'd0, err: 1'b1, lat: 1});
    send(1, 1, 3'b010, 32'h101, 32'h12345678); wait_done();
    exp_rsp0.push_back('{rdata: 32'd0, err: 1'b0, lat: 2});
    send(1, 1, 3'b010, 32'h100, 32'h12345678); wait_done();

    // Halfword crossing the top of the address space
    eb(1, 32'hFFFFFFFC, 4'b1000, 32'hEF000000); eb(1, 32'h00000000, 4'b0001, 32'h000000BE); er(32'd0, 0, 3);
    send(0, 1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF); wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
